// File: rtl/issue_queue_scheduler.sv
// issue_queue_scheduler: in-order uop issue queue. Accepts decoded uops in
// pairs, issues one per cycle into a registered EX slot, interlocks load-use
// hazards against the uop held in that slot, and discards everything on flush.
// Optional feature macro: BRANCH_HOLD_EN -- when defined, issue stops after a
// branch is consumed by EX until br_resolve or flush.
module issue_queue_scheduler #(
  parameter int unsigned UOP_W = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [UOP_W-1:0] in_uop0,
  input  logic [UOP_W-1:0] in_uop1,
  input  logic [17:0]      in_meta0,
  input  logic [17:0]      in_meta1,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [UOP_W-1:0] ex_uop,
  output logic [17:0]      ex_meta,
  input  logic             br_resolve,
  input  logic             flush
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Decoded-uop sideband, packed to match the 18-bit port layout
  typedef struct packed {
    logic       is_branch;
    logic       is_load;
    logic       reg_we;
    logic [4:0] dst;
    logic [4:0] src2;
    logic [4:0] src1;
  } meta_t;

  // Queue storage and bookkeeping
  logic [UOP_W-1:0] uop_q  [DEPTH];
  meta_t            meta_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Issue register metadata
  meta_t            ex_meta_q;

  // Per-cycle decisions
  logic             enq_c;
  logic             ex_free_c;
  logic             hazard_c;
  logic             hold_block_c;
  logic             issue_c;
  logic [PTR_W-1:0] wr_ptr_inc_c;
  logic [CNT_W-1:0] count_nxt_c;

  assign ex_meta = ex_meta_q;

  // Load-use interlock: the head may not issue while its source is the
  // destination of a load still sitting in the EX slot
  always_comb begin
    hazard_c = 1'b0;
    if (ex_valid && ex_meta_q.is_load && ex_meta_q.reg_we &&
        (ex_meta_q.dst != 5'd0)) begin
      hazard_c = (meta_q[rd_ptr].src1 == ex_meta_q.dst) ||
                 (meta_q[rd_ptr].src2 == ex_meta_q.dst);
    end
  end

`ifdef BRANCH_HOLD_EN
  logic br_hold;
  logic br_consume_c;

  // A branch leaving the EX slot blocks issue in that same cycle so no
  // younger uop slips past before the hold register takes over
  assign br_consume_c = ex_valid && ex_ready && ex_meta_q.is_branch;
  assign hold_block_c = br_hold || br_consume_c;

  // Branch hold: set when EX takes a branch, released by resolve or flush
  always_ff @(posedge clk) begin
    if (rst) begin
      br_hold <= 1'b0;
    end else if (flush) begin
      br_hold <= 1'b0;
    end else if (br_consume_c) begin
      br_hold <= 1'b1;
    end else if (br_resolve) begin
      br_hold <= 1'b0;
    end
  end
`else
  logic unused_br_resolve;

  // Speculative issue past branches; resolve has no effect here
  assign hold_block_c      = 1'b0;
  assign unused_br_resolve = br_resolve;
`endif

  // Enqueue/issue decisions and next occupancy (rst/flush override in the flops)
  always_comb begin
    enq_c        = in_valid && in_ready;
    ex_free_c    = !ex_valid || ex_ready;
    issue_c      = (count != '0) && !hazard_c && !hold_block_c && ex_free_c;
    wr_ptr_inc_c = wr_ptr + PTR_W'(1);
    count_nxt_c  = count;
    if (enq_c) begin
      count_nxt_c = count_nxt_c + CNT_W'(2);
    end
    if (issue_c) begin
      count_nxt_c = count_nxt_c - CNT_W'(1);
    end
  end

  // Pointers, occupancy and the registered ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (enq_c) begin
        wr_ptr <= wr_ptr + PTR_W'(2);
      end
      if (issue_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count    <= count_nxt_c;
      in_ready <= (count_nxt_c <= CNT_W'(DEPTH - 2));
    end
  end

  // Payload storage: slot0 lands at the write pointer, slot1 right behind it
  always_ff @(posedge clk) begin
    if (!rst && !flush && enq_c) begin
      uop_q[wr_ptr]        <= in_uop0;
      meta_q[wr_ptr]       <= meta_t'(in_meta0);
      uop_q[wr_ptr_inc_c]  <= in_uop1;
      meta_q[wr_ptr_inc_c] <= meta_t'(in_meta1);
    end
  end

  // Issue register: loads the head, holds while EX stalls, empties when consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_uop    <= '0;
      ex_meta_q <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (issue_c) begin
      ex_valid  <= 1'b1;
      ex_uop    <= uop_q[rd_ptr];
      ex_meta_q <= meta_q[rd_ptr];
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_issue_queue_scheduler.sv
// Bench for issue_queue_scheduler: scoreboard of accepted uops checked in
// program order as EX consumes them, plus cycle-exact directed checks.
// Build with BRANCH_HOLD_EN defined to exercise the branch hold variant.
module tb_issue_queue_scheduler;

  localparam int unsigned UOP_W = 128;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [UOP_W-1:0] in_uop0;
  logic [UOP_W-1:0] in_uop1;
  logic [17:0]      in_meta0;
  logic [17:0]      in_meta1;
  logic             ex_valid;
  logic             ex_ready;
  logic [UOP_W-1:0] ex_uop;
  logic [17:0]      ex_meta;
  logic             br_resolve;
  logic             flush;

  typedef struct packed {
    logic [127:0] uop;
    logic [17:0]  meta;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  issue_queue_scheduler #(
    .UOP_W(UOP_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_uop0   (in_uop0),
    .in_uop1   (in_uop1),
    .in_meta0  (in_meta0),
    .in_meta1  (in_meta1),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_uop    (ex_uop),
    .ex_meta   (ex_meta),
    .br_resolve(br_resolve),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] mk(input logic br, input logic ld, input logic we,
                                     input logic [4:0] dst, input logic [4:0] s2,
                                     input logic [4:0] s1);
    return {br, ld, we, dst, s2, s1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ex(input string tag, input logic v, input logic [127:0] u);
    check({tag, "_v"}, 128'(ex_valid), 128'(v));
    if (v) check({tag, "_uop"}, ex_uop, u);
  endtask

  // Offer one pair for one cycle; acc is the bench's own expectation of in_ready
  task automatic drive_pair(input logic [127:0] u0, input logic [17:0] m0,
                            input logic [127:0] u1, input logic [17:0] m1,
                            input logic acc);
    exp_t e;
    in_uop0  = u0;
    in_meta0 = m0;
    in_uop1  = u1;
    in_meta1 = m1;
    in_valid = 1'b1;
    check("in_ready", 128'(in_ready), 128'(acc));
    if (acc) begin
      e.uop = u0; e.meta = m0; sb.push_back(e);
      e.uop = u1; e.meta = m1; sb.push_back(e);
    end
    step();
    in_valid = 1'b0;
  endtask

  // Load followed by a dependent/independent uop; bubble says whether one
  // empty EX cycle must separate them
  task automatic hz_case(input string tag, input logic [17:0] m0, input logic [17:0] m1,
                         input logic bubble, input logic [127:0] u0, input logic [127:0] u1);
    drive_pair(u0, m0, u1, m1, 1'b1);
    step();
    check_ex({tag, "_ld"}, 1'b1, u0);
    step();
    if (bubble) begin
      check_ex({tag, "_bub"}, 1'b0, '0);
      step();
    end
    check_ex({tag, "_use"}, 1'b1, u1);
    step();
    check_ex({tag, "_done"}, 1'b0, '0);
  endtask

  // Scoreboard: every uop EX takes must be the oldest accepted one
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !flush && ex_valid && ex_ready) begin
      check("sb_avail", 128'(sb.size() > 0), 128'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_uop", ex_uop, e.uop);
        check("sb_meta", 128'(ex_meta), 128'(e.meta));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    logic [17:0]  nm;
    logic [17:0]  ld5;
    logic [127:0] seq[4];

    nm  = mk(1'b0, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2);
    ld5 = mk(1'b0, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0);

    rst = 1'b1; in_valid = 1'b0; in_uop0 = '0; in_uop1 = '0;
    in_meta0 = '0; in_meta1 = '0; ex_ready = 1'b1; br_resolve = 1'b0; flush = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_ex_valid", 128'(ex_valid), 128'd0);
    check("rst_ex_uop", ex_uop, 128'd0);
    check("rst_ex_meta", 128'(ex_meta), 128'd0);

    // Two pairs, back-to-back issue A,B,C,D
    drive_pair(128'hA, nm, 128'hB, nm, 1'b1);
    check("t1_rdy0", 128'(in_ready), 128'd1);
    check_ex("t1_pre", 1'b0, '0);
    step();
    check_ex("t1_a", 1'b1, 128'hA);
    drive_pair(128'hC, nm, 128'hD, nm, 1'b1);
    seq[0] = 128'hB; seq[1] = 128'hC; seq[2] = 128'hD;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      check_ex("t1_seq", 1'b1, seq[i]);
      check("t1_rdy", 128'(in_ready), 128'd1);
    end

    // EX stalls on D: fill the queue to DEPTH, extra pair refused
    ex_ready = 1'b0;
    drive_pair(128'hE, nm, 128'hF, nm, 1'b1);
    drive_pair(128'h10, nm, 128'h11, nm, 1'b1);
    check("t2_full", 128'(in_ready), 128'd0);
    drive_pair(128'h12, nm, 128'h13, nm, 1'b0);
    check("t2_full2", 128'(in_ready), 128'd0);
    check_ex("t2_stable", 1'b1, 128'hD);
    ex_ready = 1'b1;
    seq[0] = 128'hE; seq[1] = 128'hF; seq[2] = 128'h10; seq[3] = 128'h11;
    for (int i = 0; i < 4; i++) begin
      step();
      check_ex("t2_drain", 1'b1, seq[i]);
    end
    step();
    check_ex("t2_empty", 1'b0, '0);
    check("t2_rdy", 128'(in_ready), 128'd1);

    // Load-use interlock
    hz_case("hz_s1", ld5, mk(1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 5'd5), 1'b1, 128'h20, 128'h21);
    hz_case("hz_s2", ld5, mk(1'b0, 1'b0, 1'b1, 5'd7, 5'd5, 5'd0), 1'b1, 128'h22, 128'h23);
    hz_case("hz_s6", ld5, mk(1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 5'd6), 1'b0, 128'h24, 128'h25);
    hz_case("hz_d0", mk(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0),
            mk(1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 5'd0), 1'b0, 128'h26, 128'h27);
    hz_case("hz_nowe", mk(1'b0, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0),
            mk(1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 5'd5), 1'b0, 128'h28, 128'h29);

    // Branch consumed, resolve pulse three cycles later
    drive_pair(128'h30, mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0), 128'h31, nm, 1'b1);
    step();
    check_ex("br_issue", 1'b1, 128'h30);
    step();
`ifdef BRANCH_HOLD_EN
    check_ex("br_hold1", 1'b0, '0);
    step();
    check_ex("br_hold2", 1'b0, '0);
    step();
    check_ex("br_hold3", 1'b0, '0);
    br_resolve = 1'b1;
    step();
    br_resolve = 1'b0;
    check_ex("br_release", 1'b0, '0);
    step();
    check_ex("br_next", 1'b1, 128'h31);
`else
    check_ex("br_next", 1'b1, 128'h31);
    br_resolve = 1'b1;
`endif
    step();
    br_resolve = 1'b0;
    check_ex("br_done", 1'b0, '0);

    // Flush with three queued uops and a full EX slot, pair offered alongside
    ex_ready = 1'b0;
    drive_pair(128'h40, nm, 128'h41, nm, 1'b1);
    drive_pair(128'h42, nm, 128'h43, nm, 1'b1);
    check_ex("fl_pre", 1'b1, 128'h40);
    check("fl_pre_rdy", 128'(in_ready), 128'd0);
    flush = 1'b1; in_valid = 1'b1; in_uop0 = 128'h44; in_uop1 = 128'h45;
    sb.delete();
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_ex("fl_ex", 1'b0, '0);
    check("fl_rdy", 128'(in_ready), 128'd1);
    ex_ready = 1'b1;
    step();
    step();
    check_ex("fl_empty", 1'b0, '0);

    // Flush while the queue could accept: offered pair must be dropped
    ex_ready = 1'b0;
    drive_pair(128'h50, nm, 128'h51, nm, 1'b1);
    step();
    check_ex("fl2_pre", 1'b1, 128'h50);
    check("fl2_pre_rdy", 128'(in_ready), 128'd1);
    flush = 1'b1; in_valid = 1'b1; in_uop0 = 128'h52; in_uop1 = 128'h53;
    sb.delete();
    step();
    flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
    check_ex("fl2_ex", 1'b0, '0);
    step();
    step();
    check_ex("fl2_empty", 1'b0, '0);
    check("fl2_rdy", 128'(in_ready), 128'd1);

    // Reset (with flush) during simultaneous enqueue and issue
    drive_pair(128'h60, nm, 128'h61, nm, 1'b1);
    in_valid = 1'b1; in_uop0 = 128'h62; in_uop1 = 128'h63;
    rst = 1'b1; flush = 1'b1;
    sb.delete();
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("mr_in_ready", 128'(in_ready), 128'd1);
    check("mr_ex_valid", 128'(ex_valid), 128'd0);
    check("mr_ex_uop", ex_uop, 128'd0);
    check("mr_ex_meta", 128'(ex_meta), 128'd0);
    step();
    step();
    check_ex("mr_empty", 1'b0, '0);

    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/issue_queue_scheduler.md
ISSUE_QUEUE_SCHEDULER -- requirements
Module: issue_queue_scheduler

Interface
REQ-001 Parameter UOP_W, default 128, width of the opaque decoded-uop payload.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  decode offers a pair of uops (slot0 older than slot1).
REQ-006 in_ready  output  1  queue accepts a pair this cycle.
REQ-007 in_uop0, in_uop1  input  UOP_W each  slot0/slot1 payloads.
REQ-008 in_meta0, in_meta1  input  18 each  {is_branch[17], is_load[16], reg_we[15], dst[14:10], src2[9:5], src1[4:0]}.
REQ-009 ex_valid  output  1  issue register holds a uop for EX.
REQ-010 ex_ready  input  1  EX consumes the issue register this cycle.
REQ-011 ex_uop  output  UOP_W  issued payload.
REQ-012 ex_meta  output  18  issued metadata, same layout as in_meta0.
REQ-013 br_resolve  input  1  one-cycle pulse: oldest outstanding branch resolved.
REQ-014 flush  input  1  branch taken; discard all younger uops.

Function
REQ-015 Pair accepted on in_valid && in_ready; slot0 enqueued before slot1; both or neither.
REQ-016 in_ready SHALL be 1 iff registered occupancy count <= DEPTH-2, derived from registers only.
REQ-017 Issue order strictly program order from queue head; at most one uop issued per cycle.
REQ-018 Issue (head moved into issue register, ex_valid=1 next cycle) when queue non-empty, no hazard, no branch hold, and (!ex_valid || ex_ready).
REQ-019 ex_valid/ex_uop/ex_meta SHALL remain stable while ex_valid && !ex_ready.
REQ-020 Load-use hazard: issue register holds a uop with is_load=1, reg_we=1, dst!=0, and head src1 or src2 equals that dst -> head not issued; after EX consumes the load, ex_valid=0 for exactly one cycle, then head issues.
REQ-021 Enqueue and issue in the same cycle SHALL both occur; count updates by +2-1.
REQ-022 Read/write pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-023 flush: next cycle count=0, pointers equal, ex_valid=0, branch hold cleared; in_valid and issue ignored in flush cycle; flush has priority over all other events.
REQ-024 in_valid while !in_ready SHALL NOT change queue contents.

Reset
REQ-025 rst: count=0, pointers=0, ex_valid=0, ex_uop=0, ex_meta=0, branch hold=0, hazard state cleared; in_ready=1 the cycle after reset.
REQ-026 rst asserted mid-operation discards all queued and issued uops; rst has priority over flush.

Configuration
REQ-027 Macro BRANCH_HOLD_EN defined: after a uop with is_branch=1 is consumed by EX, no further issue until br_resolve or flush; br_resolve releases hold the following cycle.
REQ-028 Macro BRANCH_HOLD_EN undefined: no hold; issue continues speculatively past branches, br_resolve ignored, flush alone discards wrong-path uops.

Verification
REQ-029 Reset, ex_ready=1, push pairs A/B then C/D (non-hazard) -> ex_uop A,B,C,D on four consecutive cycles, in_ready stays 1.
REQ-030 ex_ready=0, push pairs until in_ready=0 -> count=4 with DEPTH=4, further in_valid ignored; raise ex_ready -> four uops drain in order.
REQ-031 Issue load dst=5, next uop src1=5 -> exactly one ex_valid=0 bubble after load consumed; src1=6 instead -> no bubble; dst=0 -> no bubble.
REQ-032 With BRANCH_HOLD_EN: branch consumed, br_resolve 3 cycles later -> no issue for 3 cycles, next uop issues cycle after pulse; without macro -> no gap.
REQ-033 Queue holding 3 uops plus valid issue register, flush with simultaneous in_valid -> next cycle ex_valid=0, count=0, in_ready=1, nothing enqueued.
REQ-034 rst asserted during simultaneous enqueue+issue -> all outputs at reset values next cycle.
